// File: rtl/btb_predictor.sv
// btb_predictor: 8-entry direct-mapped branch target buffer for the lc3b pipeline.
//   Fetch side : fetch_valid/fetch_pc looked up, registered pred_valid/hit/taken/target.
//   Update side: upd_valid/upd_ready handshake with upd_pc/upd_target/upd_taken into a
//                small FIFO, drained one record per cycle into the table.
//   flush      : invalidates all entries and drops queued updates.
// Ports: clk, rst (async active-high), fetch_valid, fetch_pc, pred_valid, pred_hit,
//        pred_taken, pred_target, upd_valid, upd_ready, upd_pc, upd_target, upd_taken,
//        flush; with BTB_STATS_EN defined also stat_lookups, stat_hits.
// Optional feature macro: BTB_STATS_EN (saturating lookup/hit counters).
module btb_predictor #(
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned TAG_W      = 12,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] stat_lookups,
    output logic [15:0] stat_hits
`endif
);
    localparam int unsigned Entries = 2 ** IDX_W;
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StWrite} drain_state_e;

    // Table
    logic             tbl_valid  [Entries];
    logic [TAG_W-1:0] tbl_tag    [Entries];
    logic [15:0]      tbl_target [Entries];
    logic [1:0]       tbl_ctr    [Entries];

    // Update FIFO
    logic [15:1]     fifo_pc     [FIFO_DEPTH];
    logic [15:0]     fifo_target [FIFO_DEPTH];
    logic            fifo_taken  [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;

    drain_state_e state_q, state_d;
    logic         enq, pop;

    // Bit 0 of a PC never selects an entry.
    logic unused_pc_lsb;
    assign unused_pc_lsb = fetch_pc[0] ^ upd_pc[0];

    // Lookup against current table contents (pre-drain-write on the same edge).
    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_hit, lkp_taken;
    assign lkp_idx   = fetch_pc[IDX_W:1];
    assign lkp_tag   = fetch_pc[15:IDX_W+1];
    assign lkp_hit   = tbl_valid[lkp_idx] && (tbl_tag[lkp_idx] == lkp_tag);
    assign lkp_taken = lkp_hit && tbl_ctr[lkp_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 16'h0000;
        end else begin
            pred_valid  <= fetch_valid;
            pred_hit    <= fetch_valid && lkp_hit;
            pred_taken  <= fetch_valid && lkp_taken;
            pred_target <= (fetch_valid && lkp_taken) ? tbl_target[lkp_idx] : 16'h0000;
        end
    end

    // FIFO bookkeeping
    assign enq = upd_valid && upd_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(enq) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            upd_ready <= 1'b1;
        end else begin
            count_q   <= count_d;
            upd_ready <= (count_d < CntW'(FIFO_DEPTH));
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (enq) wptr_q <= wptr_q + PtrW'(1);
                if (pop) rptr_q <= rptr_q + PtrW'(1);
            end
        end
    end

    // Payload storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            fifo_pc[wptr_q]     <= upd_pc[15:1];
            fifo_target[wptr_q] <= upd_target;
            fifo_taken[wptr_q]  <= upd_taken;
        end
    end

    // Drain FSM: state register / next state / outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (count_d != '0) ? StWrite : StIdle;
    end

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StIdle:  pop = 1'b0;
            StWrite: pop = 1'b1;
            default: pop = 1'b0;
        endcase
    end

    // Apply the head record to the table
    logic [15:1]      drn_pc;
    logic [IDX_W-1:0] drn_idx;
    logic [TAG_W-1:0] drn_tag;
    logic             drn_hit;
    assign drn_pc  = fifo_pc[rptr_q];
    assign drn_idx = drn_pc[IDX_W:1];
    assign drn_tag = drn_pc[15:IDX_W+1];
    assign drn_hit = tbl_valid[drn_idx] && (tbl_tag[drn_idx] == drn_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= 16'h0000;
                tbl_ctr[i]    <= 2'b01;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < Entries; i++) tbl_valid[i] <= 1'b0;
        end else if (pop) begin
            if (drn_hit) begin
                if (fifo_taken[rptr_q]) begin
                    if (tbl_ctr[drn_idx] != 2'b11) tbl_ctr[drn_idx] <= tbl_ctr[drn_idx] + 2'b01;
                    tbl_target[drn_idx] <= fifo_target[rptr_q];
                end else if (tbl_ctr[drn_idx] != 2'b00) begin
                    tbl_ctr[drn_idx] <= tbl_ctr[drn_idx] - 2'b01;
                end
            end else if (fifo_taken[rptr_q]) begin
                // Allocation replaces whatever lived at this index.
                tbl_valid[drn_idx]  <= 1'b1;
                tbl_tag[drn_idx]    <= drn_tag;
                tbl_target[drn_idx] <= fifo_target[rptr_q];
                tbl_ctr[drn_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTB_STATS_EN
    // Saturating counters; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= 16'h0000;
            stat_hits    <= 16'h0000;
        end else begin
            if (fetch_valid && stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'h0001;
            if (fetch_valid && lkp_hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed scenarios plus randomized traffic against a behavioural
// BTB model (arrays + update queue) for btb_predictor.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_pc = 16'h0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_pc = 16'h0, upd_target = 16'h0;
    logic        upd_taken = 1'b0;
    logic        flush = 1'b0;
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups, stat_hits;
`endif

    btb_predictor dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush)
`ifdef BTB_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
        bit          tk;
    } upd_t;

    bit          m_valid [8];
    int          m_tag   [8];
    logic [15:0] m_tgt   [8];
    int          m_ctr   [8];
    upd_t        m_q[$];
    int          m_lookups, m_hits;

    bit          e_pv, e_hit, e_tk, e_rdy;
    logic [15:0] e_tgt;

    function automatic int idx_of(logic [15:0] pc); return (int'(pc) / 2) % 8; endfunction
    function automatic int tag_of(logic [15:0] pc); return int'(pc) / 16; endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 16'h0; m_ctr[i] = 1;
        end
        m_q.delete();
        m_lookups = 0; m_hits = 0;
        e_pv = 0; e_hit = 0; e_tk = 0; e_tgt = 16'h0; e_rdy = 1;
    endfunction

    function automatic void model_apply(upd_t u);
        int i = idx_of(u.pc);
        bit h = m_valid[i] && m_tag[i] == tag_of(u.pc);
        if (h) begin
            if (u.tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = u.tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (u.tk) begin
            m_valid[i] = 1; m_tag[i] = tag_of(u.pc); m_tgt[i] = u.tgt; m_ctr[i] = 2;
        end
    endfunction

    // One clock edge of behaviour; returns whether the offered update was accepted.
    function automatic bit model_step(bit fv, logic [15:0] fpc, bit uv, logic [15:0] upc,
                                      logic [15:0] utgt, bit utk, bit fl);
        bit   acc = uv && (m_q.size() < 2);
        int   i   = idx_of(fpc);
        upd_t u;
        e_pv  = fv;
        e_hit = fv && m_valid[i] && m_tag[i] == tag_of(fpc);
        e_tk  = e_hit && m_ctr[i] >= 2;
        e_tgt = e_tk ? m_tgt[i] : 16'h0;
        if (fv && m_lookups < 65535) m_lookups++;
        if (e_hit && m_hits < 65535) m_hits++;
        if (fl) begin
            for (int k = 0; k < 8; k++) m_valid[k] = 0;
            m_q.delete();
        end else begin
            if (m_q.size() > 0) model_apply(m_q.pop_front());
            if (acc) begin
                u.pc = upc; u.tgt = utgt; u.tk = utk;
                m_q.push_back(u);
            end
        end
        e_rdy = m_q.size() < 2;
        return acc;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".pred_valid"}, 32'(pred_valid), 32'(e_pv));
        check({tag, ".pred_hit"}, 32'(pred_hit), 32'(e_hit));
        check({tag, ".pred_taken"}, 32'(pred_taken), 32'(e_tk));
        check({tag, ".pred_target"}, 32'(pred_target), 32'(e_tgt));
        check({tag, ".upd_ready"}, 32'(upd_ready), 32'(e_rdy));
`ifdef BTB_STATS_EN
        check({tag, ".stat_lookups"}, 32'(stat_lookups), 32'(m_lookups));
        check({tag, ".stat_hits"}, 32'(stat_hits), 32'(m_hits));
`endif
    endtask

    // Called at a negedge: drive, step model, advance to next negedge, check.
    task automatic tick(input string tag, input bit fv, input logic [15:0] fpc, input bit uv,
                        input logic [15:0] upc, input logic [15:0] utgt, input bit utk,
                        input bit fl, output bit acc);
        fetch_valid = fv; fetch_pc = fpc;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk;
        flush = fl;
        acc = model_step(fv, fpc, uv, upc, utgt, utk, fl);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        bit a;
        tick(tag, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, a);
    endtask

    task automatic lookup(input string tag, input logic [15:0] pc);
        bit a;
        tick(tag, 1, pc, 0, 16'h0, 16'h0, 0, 0, a);
    endtask

    task automatic update(input string tag, input logic [15:0] pc, input logic [15:0] tgt,
                          input bit tk);
        bit a;
        tick(tag, 0, 16'h0, 1, pc, tgt, tk, 0, a);
        check({tag, ".accepted"}, 32'(a), 32'd1);
    endtask

    initial begin
        bit          acc;
        bit          r_uv;
        logic [15:0] r_upc, r_utgt, r_fpc;
        bit          r_utk, r_fv, r_fl;

        model_reset();
        repeat (2) @(negedge clk);
        check("reset.pred_valid", 32'(pred_valid), 32'd0);
        check("reset.upd_ready", 32'(upd_ready), 32'd1);
        rst = 1'b0;

        // 1) cold lookup misses
        lookup("t1", 16'h3004);
        check("t1.hit_const", 32'(pred_hit), 32'd0);
        check("t1.valid_const", 32'(pred_valid), 32'd1);

        // 2) taken update allocates
        update("t2.upd", 16'h3004, 16'h3100, 1);
        idle("t2.w0");
        idle("t2.w1");
        lookup("t2.lkp", 16'h3004);
        check("t2.taken_const", 32'(pred_taken), 32'd1);
        check("t2.target_const", 32'(pred_target), 32'h3100);

        // 3) two not-taken updates walk counter 10->01->00
        update("t3.u0", 16'h3004, 16'h3100, 0);
        update("t3.u1", 16'h3004, 16'h3100, 0);
        idle("t3.w");
        lookup("t3.lkp", 16'h3004);
        check("t3.hit_const", 32'(pred_hit), 32'd1);
        check("t3.taken_const", 32'(pred_taken), 32'd0);
        check("t3.target_const", 32'(pred_target), 32'h0);

        // 4) back-to-back updates never stall a 1/cycle drain
        update("t4.u0", 16'h3040, 16'h4000, 1);
        check("t4.ready0", 32'(upd_ready), 32'd1);
        update("t4.u1", 16'h3042, 16'h4002, 1);
        update("t4.u2", 16'h3046, 16'h4006, 1);
        update("t4.u3", 16'h3048, 16'h4008, 1);
        check("t4.ready3", 32'(upd_ready), 32'd1);
        idle("t4.w");

        // 5) alias on the same index replaces the old entry
        update("t5.upd", 16'h3024, 16'h3200, 1);
        idle("t5.w");
        lookup("t5.old", 16'h3004);
        check("t5.old_miss", 32'(pred_hit), 32'd0);
        lookup("t5.new", 16'h3024);
        check("t5.new_hit", 32'(pred_hit), 32'd1);
        check("t5.new_target", 32'(pred_target), 32'h3200);

        // 6) flush with a queued update; same-cycle lookup sees pre-flush state
        update("t6.upd", 16'h3040, 16'h5000, 1);
        tick("t6.flush", 1, 16'h3024, 1, 16'h3048, 16'h6000, 1, 1, acc);
        check("t6.flush_lkp_hit", 32'(pred_hit), 32'd1);
        lookup("t6.after", 16'h3024);
        check("t6.after_miss", 32'(pred_hit), 32'd0);
        check("t6.ready", 32'(upd_ready), 32'd1);
        idle("t6.w");
        lookup("t6.dropped", 16'h3048);
        check("t6.dropped_miss", 32'(pred_hit), 32'd0);

        // 7) async reset mid-drain
        update("t7.a", 16'h3010, 16'h7000, 1);
        tick("t7.b", 1, 16'h3012, 1, 16'h3012, 16'h7002, 1, 0, acc);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("t7.async");
        @(negedge clk);
        rst = 1'b0;
        lookup("t7.lkp", 16'h3012);
        check("t7.miss", 32'(pred_hit), 32'd0);

        // Randomized traffic; a refused record is held until accepted.
        r_uv = 0; r_upc = 16'h0; r_utgt = 16'h0; r_utk = 0;
        for (int n = 0; n < 600; n++) begin
            if (!r_uv) begin
                r_uv   = ($urandom_range(0, 2) != 0);
                r_upc  = 16'(16'h3000 | ($urandom_range(0, 1) << 5) | ($urandom_range(0, 7) << 1)
                              | $urandom_range(0, 1));
                r_utgt = 16'($urandom);
                r_utk  = ($urandom_range(0, 3) != 0);
            end
            r_fv  = ($urandom_range(0, 1) != 0);
            r_fpc = 16'(16'h3000 | ($urandom_range(0, 1) << 5) | ($urandom_range(0, 7) << 1)
                         | $urandom_range(0, 1));
            r_fl  = ($urandom_range(0, 40) == 0);
            tick("rnd", r_fv, r_fpc, r_uv, r_upc, r_utgt, r_utk, r_fl, acc);
            if (acc || r_fl) r_uv = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
